reg_access_arbiter: RTL and testbench

- Shares one `registerInterface` instance between two requesters: port 0 (I2C slave FSM) and port 1 (local host/debug bus).
- Round-robin arbitration, one access in flight at a time, req/ack handshake per port.
- Drives the interface's addr/dataIn/writeEn, captures its registered dataOut, and presents the owning requester's security domain tag on `ri_domain`.

---
 rtl/reg_arb_pkg.sv | 25 ++
 rtl/rr_arb2.sv | 22 ++
 rtl/reg_access_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_reg_access_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the register-access arbiter slice.
// Optional write-lock input is enabled by defining REG_ARB_WRITE_LOCK_EN.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_COMPLETE = 2'd2
  } arb_state_e;

  localparam logic REQ_I2C  = 1'b0;
  localparam logic REQ_HOST = 1'b1;

  localparam int unsigned DEF_ADDR_W   = 8;
  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_WR_REGS  = 4;
  localparam int unsigned DEF_NUM_REGS = 8;

  // A write is rejected when it targets a read-only address or the port is locked.
  function automatic logic is_write_rejected(input logic we, input logic addr_ro,
                                             input logic locked);
    return we & (addr_ro | locked);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker: on a tie the port that was not
// granted last time wins.
module rr_arb2
  import reg_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       gnt_valid_o,
  output logic       gnt_id_o
);

  always_comb begin
    gnt_valid_o = |req_i;
    gnt_id_o    = REQ_I2C;
    if (req_i == 2'b11) begin
      gnt_id_o = ~last_grant_i;
    end else if (req_i[1]) begin
      gnt_id_o = REQ_HOST;
    end
  end

endmodule

// File: rtl/reg_access_arbiter.sv
// Shares one registerInterface between the I2C slave (port 0) and the host bus
// (port 1). Define REG_ARB_WRITE_LOCK_EN to add the wr_lock input for port 1.
module reg_access_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned WR_REGS  = DEF_WR_REGS,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
`ifdef REG_ARB_WRITE_LOCK_EN
  input  logic              wr_lock,
`endif
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              dom0,
  input  logic              dom1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] ri_addr,
  output logic [DATA_W-1:0] ri_dataIn,
  output logic              ri_writeEn,
  output logic              ri_domain,
  input  logic [DATA_W-1:0] ri_dataOut,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic              rej_q, rej_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] ri_addr_q, ri_addr_d;
  logic [DATA_W-1:0] ri_dataIn_q, ri_dataIn_d;
  logic              ri_writeEn_q, ri_writeEn_d;
  logic              ri_domain_q, ri_domain_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic              gnt_valid, gnt_id;
  logic              sel_we, sel_dom, sel_ro, sel_lock, sel_rej;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata, rd_value;

  rr_arb2 u_rr_arb2 (
    .req_i        ({req1, req0}),
    .last_grant_i (last_grant_q),
    .gnt_valid_o  (gnt_valid),
    .gnt_id_o     (gnt_id)
  );

  always_comb begin
    sel_we    = (gnt_id == REQ_HOST) ? we1    : we0;
    sel_addr  = (gnt_id == REQ_HOST) ? addr1  : addr0;
    sel_wdata = (gnt_id == REQ_HOST) ? wdata1 : wdata0;
    sel_dom   = (gnt_id == REQ_HOST) ? dom1   : dom0;
`ifdef REG_ARB_WRITE_LOCK_EN
    sel_lock  = (gnt_id == REQ_HOST) && wr_lock;
`else
    sel_lock  = 1'b0;
`endif
    sel_ro    = 32'(sel_addr) >= WR_REGS;
    sel_rej   = is_write_rejected(sel_we, sel_ro, sel_lock);
    // Unimplemented addresses read as zero regardless of what the interface returns.
    rd_value  = (32'(ri_addr_q) >= NUM_REGS) ? '0 : ri_dataOut;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    rej_d        = rej_q;
    rd_d         = rd_q;
    ri_addr_d    = ri_addr_q;
    ri_dataIn_d  = ri_dataIn_q;
    ri_writeEn_d = ri_writeEn_q;
    ri_domain_d  = ri_domain_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          owner_d      = gnt_id;
          last_grant_d = gnt_id;
          rej_d        = sel_rej;
          rd_d         = ~sel_we;
          ri_addr_d    = sel_addr;
          ri_dataIn_d  = sel_wdata;
          ri_writeEn_d = sel_we & ~sel_rej;
          ri_domain_d  = sel_dom;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        ri_writeEn_d = 1'b0;
        state_d      = ST_COMPLETE;
      end
      ST_COMPLETE: begin
        // ri_dataOut is valid here; capture it on the edge that raises ack.
        if (owner_q == REQ_HOST) begin
          ack1_d = 1'b1;
          err1_d = rej_q;
          if (rd_q) rdata1_d = rd_value;
        end else begin
          ack0_d = 1'b1;
          err0_d = rej_q;
          if (rd_q) rdata0_d = rd_value;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= REQ_HOST;
      owner_q      <= REQ_I2C;
      rej_q        <= 1'b0;
      rd_q         <= 1'b0;
      ri_addr_q    <= '0;
      ri_dataIn_q  <= '0;
      ri_writeEn_q <= 1'b0;
      ri_domain_q  <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      rej_q        <= rej_d;
      rd_q         <= rd_d;
      ri_addr_q    <= ri_addr_d;
      ri_dataIn_q  <= ri_dataIn_d;
      ri_writeEn_q <= ri_writeEn_d;
      ri_domain_q  <= ri_domain_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign err0       = err0_q;
  assign err1       = err1_q;
  assign rdata0     = rdata0_q;
  assign rdata1     = rdata1_q;
  assign ri_addr    = ri_addr_q;
  assign ri_dataIn  = ri_dataIn_q;
  assign ri_writeEn = ri_writeEn_q;
  assign ri_domain  = ri_domain_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Self-checking bench for reg_access_arbiter with a register-file stand-in and
// a transaction-level reference model (service order, latency, register contents).
module tb_reg_access_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_lock;
  logic       req0, req1, we0, we1, dom0, dom1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       ack0, ack1, err0, err1;
  logic [7:0] rdata0, rdata1;
  logic [7:0] ri_addr, ri_dataIn, ri_dataOut;
  logic       ri_writeEn, ri_domain, busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reg_access_arbiter #(.ADDR_W(8), .DATA_W(8), .WR_REGS(4), .NUM_REGS(8)) dut (
    .clk(clk), .rst(rst),
`ifdef REG_ARB_WRITE_LOCK_EN
    .wr_lock(wr_lock),
`endif
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .dom0(dom0), .dom1(dom1), .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1), .ri_addr(ri_addr), .ri_dataIn(ri_dataIn),
    .ri_writeEn(ri_writeEn), .ri_domain(ri_domain), .ri_dataOut(ri_dataOut), .busy(busy)
  );

  // registerInterface stand-in; returns junk above the implemented range
  logic [7:0] regfile [8] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h3C, 8'h5A, 8'h66, 8'h77};
  always @(posedge clk) begin
    if (ri_writeEn && ri_addr < 8'd8) regfile[ri_addr[2:0]] <= ri_dataIn;
    ri_dataOut <= (ri_addr < 8'd8) ? regfile[ri_addr[2:0]] : (8'hE0 | ri_addr);
  end

  // reference model state
  logic [7:0] mdl_mem [8] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h3C, 8'h5A, 8'h66, 8'h77};
  logic [7:0] mdl_rd [2];
  logic       mdl_last;

  // per-port transaction slots, results and expectations
  logic       p_we [2];
  logic       p_dom [2];
  logic [7:0] p_addr [2];
  logic [7:0] p_wd [2];
  int         r_lat [2], r_nack [2], r_wen [2];
  logic [7:0] r_rd [2];
  logic       r_err [2], r_domok [2];
  int         e_lat [2], e_wen [2];
  logic [7:0] e_rd [2];
  logic       e_err [2];

  task automatic set_port(input int p, input logic we, input logic [7:0] addr,
                          input logic [7:0] wd, input logic dom);
    p_we[p] = we; p_addr[p] = addr; p_wd[p] = wd; p_dom[p] = dom;
  endtask

  task automatic predict(input logic [1:0] act);
    int   order [2];
    int   n;
    int   p;
    logic ok, lock;
`ifdef REG_ARB_WRITE_LOCK_EN
    lock = wr_lock;
`else
    lock = 1'b0;
`endif
    if (act == 2'b11) begin
      order[0] = mdl_last ? 0 : 1;
      order[1] = 1 - order[0];
      n = 2;
    end else begin
      order[0] = act[1] ? 1 : 0;
      order[1] = 0;
      n = 1;
    end
    for (int k = 0; k < n; k++) begin
      p = order[k];
      e_lat[p] = 3 * (k + 1);
      ok = p_we[p] && (p_addr[p] < 8'd4) && !(lock && p == 1);
      e_err[p] = p_we[p] && !ok;
      e_wen[p] = ok ? 1 : 0;
      if (!p_we[p]) mdl_rd[p] = (p_addr[p] < 8'd8) ? mdl_mem[p_addr[p][2:0]] : 8'h00;
      e_rd[p] = mdl_rd[p];
      if (ok) mdl_mem[p_addr[p][2:0]] = p_wd[p];
      mdl_last = (p == 1);
    end
  endtask

  task automatic run_txn(input logic [1:0] act);
    logic lg_dom [0:40];
    logic lg_wen [0:40];
    logic done [2];
    int   tail;
    @(posedge clk); #1;
    we0 = p_we[0]; addr0 = p_addr[0]; wdata0 = p_wd[0]; dom0 = p_dom[0];
    we1 = p_we[1]; addr1 = p_addr[1]; wdata1 = p_wd[1]; dom1 = p_dom[1];
    req0 = act[0]; req1 = act[1];
    for (int p = 0; p < 2; p++) begin
      done[p] = 1'b0; r_nack[p] = 0; r_lat[p] = 0; r_wen[p] = 0;
      r_rd[p] = 8'hXX; r_err[p] = 1'bx; r_domok[p] = 1'b1;
    end
    tail = -1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      lg_dom[n] = ri_domain; lg_wen[n] = ri_writeEn;
      if (ack0) begin
        r_nack[0]++;
        if (!done[0]) begin done[0] = 1'b1; r_lat[0] = n; r_rd[0] = rdata0; r_err[0] = err0; req0 = 1'b0; end
      end
      if (ack1) begin
        r_nack[1]++;
        if (!done[1]) begin done[1] = 1'b1; r_lat[1] = n; r_rd[1] = rdata1; r_err[1] = err1; req1 = 1'b0; end
      end
      if (tail < 0 && (done[0] || !act[0]) && (done[1] || !act[1])) tail = n + 3;
      if (n == tail) break;
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int p = 0; p < 2; p++) begin
      if (done[p] && r_lat[p] >= 3) begin
        for (int k = r_lat[p] - 2; k <= r_lat[p]; k++) begin
          r_wen[p] = r_wen[p] + (lg_wen[k] ? 1 : 0);
          if (lg_dom[k] !== p_dom[p]) r_domok[p] = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_lock = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; dom0 = 0; dom1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({ack0, ack1, err0, err1, rdata0, rdata1, ri_addr, ri_dataIn, ri_writeEn, ri_domain, busy} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got ack=%b%b err=%b%b rd=%h/%h ri=%h/%h/%b/%b busy=%b want all 0",
               ack0, ack1, err0, err1, rdata0, rdata1, ri_addr, ri_dataIn, ri_writeEn, ri_domain, busy);
    end
    @(negedge clk); rst = 1'b0;
    mdl_last = 1'b1; mdl_rd[0] = '0; mdl_rd[1] = '0;
  endtask

  task automatic test_tie();
    for (int rep = 0; rep < 2; rep++) begin
      set_port(0, 1'b0, 8'h04, 8'h00, 1'b0);
      set_port(1, 1'b0, 8'h04, 8'h00, 1'b1);
      predict(2'b11);
      run_txn(2'b11);
      for (int p = 0; p < 2; p++) begin
        tests++; if (r_nack[p] !== 1) begin fails++; $display("FAIL tie_acks p%0d: got %0d want 1", p, r_nack[p]); end
        tests++; if (r_lat[p] !== 3 * (p + 1)) begin fails++; $display("FAIL tie_order p%0d: got lat %0d want %0d", p, r_lat[p], 3 * (p + 1)); end
        tests++; if (r_rd[p] !== 8'h3C) begin fails++; $display("FAIL tie_rdata p%0d: got %h want 3c", p, r_rd[p]); end
        tests++; if (r_err[p] !== 1'b0) begin fails++; $display("FAIL tie_err p%0d: got %b want 0", p, r_err[p]); end
        tests++; if (r_domok[p] !== 1'b1) begin fails++; $display("FAIL tie_domain p%0d: got mismatch want dom %b", p, p_dom[p]); end
      end
    end
  endtask

  task automatic test_write_read();
    set_port(0, 1'b1, 8'h02, 8'hA5, 1'b1);
    set_port(1, 1'b1, 8'h03, 8'hFF, 1'b0);
    predict(2'b01);
    run_txn(2'b01);
    tests++; if (r_nack[0] !== 1 || r_nack[1] !== 0) begin fails++; $display("FAIL wr_acks: got %0d/%0d want 1/0", r_nack[0], r_nack[1]); end
    tests++; if (r_lat[0] !== 3) begin fails++; $display("FAIL wr_latency: got %0d want 3", r_lat[0]); end
    tests++; if (r_wen[0] !== 1) begin fails++; $display("FAIL wr_writeEn_cycles: got %0d want 1", r_wen[0]); end
    tests++; if (r_err[0] !== 1'b0) begin fails++; $display("FAIL wr_err: got %b want 0", r_err[0]); end
    tests++; if (r_domok[0] !== 1'b1) begin fails++; $display("FAIL wr_domain: got mismatch want dom 1"); end
    set_port(0, 1'b0, 8'h02, 8'h00, 1'b0);
    predict(2'b01);
    run_txn(2'b01);
    tests++; if (r_lat[0] !== 3) begin fails++; $display("FAIL rd_latency: got %0d want 3", r_lat[0]); end
    tests++; if (r_rd[0] !== 8'hA5) begin fails++; $display("FAIL rd_after_wr: got %h want a5", r_rd[0]); end
    tests++; if (r_err[0] !== 1'b0 || r_wen[0] !== 0) begin fails++; $display("FAIL rd_flags: got err %b wen %0d want 0/0", r_err[0], r_wen[0]); end
    tests++; if (r_domok[0] !== 1'b1) begin fails++; $display("FAIL rd_domain: got mismatch want dom 0"); end
  endtask

  task automatic test_reject();
    set_port(1, 1'b1, 8'h05, 8'h11, 1'b1);
    predict(2'b10);
    run_txn(2'b10);
    tests++; if (r_nack[1] !== 1 || r_lat[1] !== 3) begin fails++; $display("FAIL rej_ack: got n=%0d lat=%0d want 1/3", r_nack[1], r_lat[1]); end
    tests++; if (r_err[1] !== 1'b1) begin fails++; $display("FAIL rej_err: got %b want 1", r_err[1]); end
    tests++; if (r_wen[1] !== 0) begin fails++; $display("FAIL rej_writeEn: got %0d want 0", r_wen[1]); end
    tests++; if (r_rd[1] !== e_rd[1]) begin fails++; $display("FAIL rej_rdata_held: got %h want %h", r_rd[1], e_rd[1]); end
    set_port(1, 1'b0, 8'h05, 8'h00, 1'b0);
    predict(2'b10);
    run_txn(2'b10);
    tests++; if (r_rd[1] !== 8'h5A) begin fails++; $display("FAIL rej_readback: got %h want 5a", r_rd[1]); end
    tests++; if (r_err[1] !== 1'b0) begin fails++; $display("FAIL rej_read_err: got %b want 0", r_err[1]); end
  endtask

  task automatic test_out_of_range();
    set_port(0, 1'b0, 8'h09, 8'h00, 1'b0);
    predict(2'b01);
    run_txn(2'b01);
    tests++; if (r_rd[0] !== 8'h00) begin fails++; $display("FAIL oor_rdata p0: got %h want 00", r_rd[0]); end
    tests++; if (r_err[0] !== 1'b0) begin fails++; $display("FAIL oor_err p0: got %b want 0", r_err[0]); end
    set_port(1, 1'b0, 8'h0B, 8'h00, 1'b1);
    predict(2'b10);
    run_txn(2'b10);
    tests++; if (r_rd[1] !== 8'h00) begin fails++; $display("FAIL oor_rdata p1: got %h want 00", r_rd[1]); end
  endtask

  task automatic test_reset_midop();
    @(posedge clk); #1;
    we0 = 1'b1; addr0 = 8'h01; wdata0 = 8'hEE; dom0 = 1'b1; req0 = 1'b1;
    @(posedge clk); #1;
    tests++; if (ri_writeEn !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL midop_issue: got wen %b busy %b want 1/1", ri_writeEn, busy); end
    #2 rst = 1'b1;
    #1;
    tests++; if (ri_writeEn !== 1'b0) begin fails++; $display("FAIL midop_async_wen: got %b want 0", ri_writeEn); end
    req0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({ack0, ack1, err0, err1, rdata0, rdata1, ri_addr, ri_dataIn, ri_writeEn, ri_domain, busy} !== '0) begin
      fails++;
      $display("FAIL midop_outputs: got ack=%b%b busy=%b ri_addr=%h want all 0", ack0, ack1, busy, ri_addr);
    end
    @(negedge clk); rst = 1'b0;
    mdl_last = 1'b1; mdl_rd[0] = '0; mdl_rd[1] = '0;
    set_port(0, 1'b0, 8'h01, 8'h00, 1'b0);
    set_port(1, 1'b0, 8'h01, 8'h00, 1'b1);
    predict(2'b11);
    run_txn(2'b11);
    tests++; if (r_lat[0] !== 3 || r_lat[1] !== 6) begin fails++; $display("FAIL midop_rr_after_reset: got lat %0d/%0d want 3/6", r_lat[0], r_lat[1]); end
    tests++; if (r_rd[1] !== e_rd[1] || r_rd[0] !== e_rd[0]) begin fails++; $display("FAIL midop_readback: got %h/%h want %h/%h", r_rd[0], r_rd[1], e_rd[0], e_rd[1]); end
  endtask

`ifdef REG_ARB_WRITE_LOCK_EN
  task automatic test_wr_lock();
    wr_lock = 1'b1;
    set_port(1, 1'b1, 8'h01, 8'h99, 1'b1);
    predict(2'b10);
    run_txn(2'b10);
    tests++; if (r_err[1] !== 1'b1 || r_wen[1] !== 0) begin fails++; $display("FAIL lock_p1_reject: got err %b wen %0d want 1/0", r_err[1], r_wen[1]); end
    set_port(0, 1'b1, 8'h01, 8'h4D, 1'b0);
    predict(2'b01);
    run_txn(2'b01);
    tests++; if (r_err[0] !== 1'b0 || r_wen[0] !== 1) begin fails++; $display("FAIL lock_p0_write: got err %b wen %0d want 0/1", r_err[0], r_wen[0]); end
    set_port(1, 1'b0, 8'h01, 8'h00, 1'b1);
    predict(2'b10);
    run_txn(2'b10);
    tests++; if (r_rd[1] !== 8'h4D) begin fails++; $display("FAIL lock_readback: got %h want 4d", r_rd[1]); end
    wr_lock = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [1:0] act;
    for (int it = 0; it < 40; it++) begin
      act = 2'($urandom_range(1, 3));
      for (int p = 0; p < 2; p++)
        set_port(p, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 11)), 8'($urandom), 1'($urandom_range(0, 1)));
`ifdef REG_ARB_WRITE_LOCK_EN
      wr_lock = 1'($urandom_range(0, 1));
`endif
      predict(act);
      run_txn(act);
      for (int p = 0; p < 2; p++) begin
        tests++; if (r_nack[p] !== (act[p] ? 1 : 0)) begin fails++; $display("FAIL rnd_acks it%0d p%0d: got %0d want %0d", it, p, r_nack[p], act[p] ? 1 : 0); end
        if (act[p]) begin
          tests++; if (r_lat[p] !== e_lat[p]) begin fails++; $display("FAIL rnd_latency it%0d p%0d: got %0d want %0d", it, p, r_lat[p], e_lat[p]); end
          tests++; if (r_rd[p] !== e_rd[p]) begin fails++; $display("FAIL rnd_rdata it%0d p%0d: got %h want %h", it, p, r_rd[p], e_rd[p]); end
          tests++; if (r_err[p] !== e_err[p]) begin fails++; $display("FAIL rnd_err it%0d p%0d: got %b want %b", it, p, r_err[p], e_err[p]); end
          tests++; if (r_wen[p] !== e_wen[p]) begin fails++; $display("FAIL rnd_writeEn it%0d p%0d: got %0d want %0d", it, p, r_wen[p], e_wen[p]); end
          tests++; if (r_domok[p] !== 1'b1) begin fails++; $display("FAIL rnd_domain it%0d p%0d: got mismatch want dom %b", it, p, p_dom[p]); end
        end
      end
    end
`ifdef REG_ARB_WRITE_LOCK_EN
    wr_lock = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_tie();
    test_write_read();
    test_reject();
    test_out_of_range();
    test_reset_midop();
`ifdef REG_ARB_WRITE_LOCK_EN
    test_wr_lock();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion within time limit want $finish");
    $fatal(1);
  end

endmodule
